// File: rtl/acc_fpu_arbiter_pkg.sv
// Shared types for the FPU arbiter slice.
// - fpu_req_t / fpu_resp_t : FPU operation and result, each with a register tag.
// - acc_owner_e            : which requester owns an outstanding op.
// - acc_slot_t             : one slot-table entry {valid, owner, original tag}.
// - slot_id_t              : slot index width for the default table depth.
package acc_fpu_arbiter_pkg;

    localparam int unsigned ACC_MAX_INFLIGHT = 4;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned REG_ADDR_W       = 5;

    typedef logic [REG_ADDR_W-1:0]               reg_addr_t;
    typedef logic [$clog2(ACC_MAX_INFLIGHT)-1:0] slot_id_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_PIV = 1'b1
    } acc_owner_e;

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        reg_addr_t         tag;
    } fpu_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [4:0]        status;
        reg_addr_t         tag;
    } fpu_resp_t;

    typedef struct packed {
        logic       valid;
        acc_owner_e owner;
        reg_addr_t  tag;
    } acc_slot_t;

endpackage

// File: rtl/acc_fpu_arbiter_if.sv
// Bundle of all handshake, bus and status signals around the FPU arbiter.
// - slave  : view taken by the arbiter (requests/FPU results in, grants/results out).
// - master : view taken by the surrounding system.
// Signal names keep their _i/_o suffixes as seen from the arbiter.
interface acc_fpu_arbiter_if
    import acc_fpu_arbiter_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = ACC_MAX_INFLIGHT
);
    logic      req0_valid_i, req0_ready_o;
    fpu_req_t  req0_i;
    logic      req1_valid_i, req1_ready_o;
    fpu_req_t  req1_i;
    logic      resp0_valid_o, resp0_ready_i;
    fpu_resp_t resp0_o;
    logic      resp1_valid_o, resp1_ready_i;
    fpu_resp_t resp1_o;
    logic      flush_i;
    logic      fpu_in_valid_o, fpu_in_ready_i;
    fpu_req_t  fpu_req_o;
    logic      fpu_out_valid_i, fpu_out_ready_o;
    fpu_resp_t fpu_resp_i;
    logic      fpu_flush_o;
    logic [$clog2(MAX_INFLIGHT):0] inflight_o;
    logic      busy_o, err_o;

    modport slave (
        input  req0_valid_i, req0_i, req1_valid_i, req1_i,
               resp0_ready_i, resp1_ready_i, flush_i,
               fpu_in_ready_i, fpu_out_valid_i, fpu_resp_i,
        output req0_ready_o, req1_ready_o, resp0_valid_o, resp0_o,
               resp1_valid_o, resp1_o, fpu_in_valid_o, fpu_req_o,
               fpu_out_ready_o, fpu_flush_o, inflight_o, busy_o, err_o
    );

    modport master (
        output req0_valid_i, req0_i, req1_valid_i, req1_i,
               resp0_ready_i, resp1_ready_i, flush_i,
               fpu_in_ready_i, fpu_out_valid_i, fpu_resp_i,
        input  req0_ready_o, req1_ready_o, resp0_valid_o, resp0_o,
               resp1_valid_o, resp1_o, fpu_in_valid_o, fpu_req_o,
               fpu_out_ready_o, fpu_flush_o, inflight_o, busy_o, err_o
    );
endinterface

// File: rtl/acc_fpu_arbiter_slot_table.sv
// Slot table for outstanding FPU ops.
// Ports: clk_i/rst_ni (async active-low), clear_i (drop every entry),
//        alloc_i/alloc_owner_i/alloc_tag_i (claim the slot on alloc_id_o),
//        free_avail_o/alloc_id_o (lowest free slot), free_i/free_id_i (retire),
//        lookup_id_i/lookup_o (read an entry), count_o (occupied slots).
module acc_fpu_arbiter_slot_table
    import acc_fpu_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = ACC_MAX_INFLIGHT,
    localparam int unsigned ID_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W = ID_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             alloc_i,
    input  acc_owner_e       alloc_owner_i,
    input  reg_addr_t        alloc_tag_i,
    output logic             free_avail_o,
    output logic [ID_W-1:0]  alloc_id_o,
    input  logic             free_i,
    input  logic [ID_W-1:0]  free_id_i,
    input  logic [ID_W-1:0]  lookup_id_i,
    output acc_slot_t        lookup_o,
    output logic [CNT_W-1:0] count_o
);
    logic [DEPTH-1:0] valid_q;
    acc_owner_e       owner_q [DEPTH];
    reg_addr_t        tag_q   [DEPTH];

    // Allocation looks only at the registered valids, so a slot retiring
    // this cycle cannot be handed out again until the next one.
    always_comb begin
        free_avail_o = 1'b0;
        alloc_id_o   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_avail_o = 1'b1;
                alloc_id_o   = ID_W'(i);
            end
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            count_o = count_o + CNT_W'(valid_q[i]);
        end
    end

    always_comb begin
        lookup_o.valid = valid_q[lookup_id_i];
        lookup_o.owner = owner_q[lookup_id_i];
        lookup_o.tag   = tag_q[lookup_id_i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else begin
            if (free_i)  valid_q[free_id_i]  <= 1'b0;
            if (alloc_i) valid_q[alloc_id_o] <= 1'b1;
        end
    end

    // Owner/tag payload is only meaningful while the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (alloc_i) begin
            owner_q[alloc_id_o] <= alloc_owner_i;
            tag_q[alloc_id_o]   <= alloc_tag_i;
        end
    end
endmodule

// File: rtl/acc_fpu_arbiter.sv
// Shares one FPU between the CPU (port 0) and the pivot sequencer (port 1).
// Ports: clk_i, rst_ni (async active-low), bus (acc_fpu_arbiter_if.slave):
//        two request ports, two response ports, the FPU request/response
//        channels, flush in/out and inflight/busy/err status.
// Each issued op carries its slot ID as FPU tag; the slot remembers the
// owner and original tag so out-of-order results route back correctly.
module acc_fpu_arbiter
    import acc_fpu_arbiter_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = ACC_MAX_INFLIGHT
) (
    input logic               clk_i,
    input logic               rst_ni,
    acc_fpu_arbiter_if.slave  bus
);
    localparam int unsigned ID_W  = $clog2(MAX_INFLIGHT);
    localparam int unsigned CNT_W = ID_W + 1;
    localparam int unsigned TAG_W = $bits(reg_addr_t);

    if (MAX_INFLIGHT < 2 || (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0) begin : g_bad_depth
        $error("MAX_INFLIGHT must be a power of two and at least 2");
    end
    if (TAG_W < ID_W) begin : g_bad_tag
        $error("FPU tag too narrow to carry a slot ID");
    end

    logic             rr_ptr_q, flush_q, err_q;
    logic             free_avail, any_req, can_issue, winner, issue;
    logic [ID_W-1:0]  alloc_id, resp_id;
    logic [CNT_W-1:0] count;
    acc_slot_t        slot;
    fpu_req_t         win_src, fpu_req;
    fpu_resp_t        resp_out;
    logic             tag_in_range, slot_hit, owner_ready, retire, bad_resp;

    assign any_req   = bus.req0_valid_i | bus.req1_valid_i;
    assign can_issue = free_avail & bus.fpu_in_ready_i & ~bus.flush_i;
    // On a tie the port that did not win last time goes first.
    assign winner    = (bus.req0_valid_i & bus.req1_valid_i) ? ~rr_ptr_q : bus.req1_valid_i;
    assign issue     = can_issue & any_req;
    assign win_src   = winner ? bus.req1_i : bus.req0_i;

    always_comb begin
        fpu_req     = win_src;
        fpu_req.tag = reg_addr_t'(alloc_id);
    end

    assign bus.fpu_in_valid_o = issue;
    assign bus.req0_ready_o   = issue & ~winner;
    assign bus.req1_ready_o   = issue & winner;
    assign bus.fpu_req_o      = fpu_req;
    assign bus.fpu_flush_o    = bus.flush_i;

    assign resp_id = bus.fpu_resp_i.tag[ID_W-1:0];
    if (TAG_W > ID_W) begin : g_tag_hi
        assign tag_in_range = ~|bus.fpu_resp_i.tag[TAG_W-1:ID_W];
    end else begin : g_tag_exact
        assign tag_in_range = 1'b1;
    end

    assign slot_hit    = tag_in_range & slot.valid;
    assign owner_ready = (slot.owner == OWN_PIV) ? bus.resp1_ready_i : bus.resp0_ready_i;
    assign retire      = bus.fpu_out_valid_i & slot_hit & owner_ready & ~bus.flush_i;
    // Results for free slots are swallowed; right after a flush they are
    // expected stragglers, otherwise they indicate a protocol fault.
    assign bad_resp    = bus.fpu_out_valid_i & ~slot_hit & ~bus.flush_i & ~flush_q;

    always_comb begin
        resp_out     = bus.fpu_resp_i;
        resp_out.tag = slot.tag;
    end

    assign bus.resp0_valid_o   = bus.fpu_out_valid_i & slot_hit & (slot.owner == OWN_CPU) & ~bus.flush_i;
    assign bus.resp1_valid_o   = bus.fpu_out_valid_i & slot_hit & (slot.owner == OWN_PIV) & ~bus.flush_i;
    assign bus.resp0_o         = resp_out;
    assign bus.resp1_o         = resp_out;
    assign bus.fpu_out_ready_o = bus.fpu_out_valid_i & (bus.flush_i | ~slot_hit | owner_ready);

    assign bus.inflight_o = count;
    assign bus.busy_o     = |count;
    assign bus.err_o      = err_q;

    acc_fpu_arbiter_slot_table #(.DEPTH(MAX_INFLIGHT)) u_slots (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (bus.flush_i),
        .alloc_i       (issue),
        .alloc_owner_i (acc_owner_e'(winner)),
        .alloc_tag_i   (win_src.tag),
        .free_avail_o  (free_avail),
        .alloc_id_o    (alloc_id),
        .free_i        (retire),
        .free_id_i     (resp_id),
        .lookup_id_i   (resp_id),
        .lookup_o      (slot),
        .count_o       (count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= 1'b0;
            flush_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (issue) rr_ptr_q <= winner;
            flush_q <= bus.flush_i;
            err_q   <= err_q | bad_resp;
        end
    end
endmodule
